debounce_multi: RTL and testbench
=================================

// Module: debounce_multi
// PURPOSE
//  N-channel push-button conditioner; successor to the single-button 4-sample debouncer.
//  Per channel:
//  - 2-flop synchroniser.
//  - Symmetric counter-based stability filter, debouncing both press and release.
//  - Outputs: debounced level, 1-cycle press/release pulses, 1-cycle long-press pulse.
//  Sits between board buttons and the control FSMs in the clk_100 domain.
// PARAMETERS
//  N_CH        4      number of independent button channels
//  STABLE_CNT  50000  consecutive cycles the input must differ from level before level flips (>=1)
//  HOLD_CNT    10000000  cycles level must stay 1 before long_press fires (>=1)
//  ACTIVE_LOW  1      1: pressed = pb_in low; 0: pressed = pb_in high
// PORTS
//  clk_100      in   1     system clock, 100 MHz
//  rst_n        in   1     asynchronous active-low reset
//  pb_in        in   N_CH  raw asynchronous button inputs
//  pb_level     out  N_CH  debounced level, 1 = pressed
//  pb_press     out  N_CH  1-cycle pulse on debounced 0->1
//  pb_release   out  N_CH  1-cycle pulse on debounced 1->0
//  pb_long      out  N_CH  1-cycle pulse when pressed for HOLD_CNT cycles
// BEHAVIOUR
//  Interface:
//  - One clock: clk_100. Reset rst_n is asynchronous and active-low.
//  - All state is in flops reset by rst_n.
//  Reset:
//  - All outputs 0; all counters 0.
//  - Synchroniser flops reset to the released value, i.e. s=0 after polarity fold.
//  Per channel, each clk_100 edge:
//  - Synchroniser: s1 <= pb_in^ACTIVE_LOW; s <= s1. Never sample raw pb_in elsewhere.
//  - Filter, s==level: stab_cnt <= 0.
//  - Filter, s!=level and stab_cnt==STABLE_CNT-1: level <= s; stab_cnt <= 0.
//    Assert pb_press (s=1) or pb_release (s=0) on the same edge that updates level.
//  - Filter, s!=level otherwise: stab_cnt <= stab_cnt+1.
//  - Bounce: any return to level before the count completes restarts it from 0.
//    Glitches shorter than STABLE_CNT cycles never reach pb_level.
//  - Latency: pb_in step to pb_level/pulse = 2 sync + STABLE_CNT cycles exactly.
//  - Long press, level==0: hold_cnt <= 0.
//  - Long press, level==1 and hold_cnt<HOLD_CNT: hold_cnt++.
//    pb_long is high for exactly the cycle hold_cnt transitions HOLD_CNT-1 -> HOLD_CNT.
//  - Long press counter saturates at HOLD_CNT: one pb_long per press, no auto-repeat.
//  - Release before HOLD_CNT: no pb_long.
//  - The pb_release following a long press still fires normally.
//  Widths:
//  - stab_cnt is $clog2(STABLE_CNT+1) bits; hold_cnt is $clog2(HOLD_CNT+1) bits.
//  - Neither counter wraps.
//  Boundary conditions:
//  - pb_press and pb_release are mutually exclusive per channel.
//    pb_long never coincides with pb_press, since HOLD_CNT>=1.
//  - Channels are fully independent; simultaneous events on several channels each produce their own pulses.
//  - Button already held when rst_n deasserts: pb_press fires 2+STABLE_CNT cycles later.
//  - rst_n asserted mid-count: all counters and outputs clear immediately and no pulse is emitted.
//  - STABLE_CNT=1: level follows s one cycle later.
// STRUCTURE
//  - Sub-module debounce_ch: one channel (sync, filter, hold counter, pulses).
//    Instantiated N_CH times in a generate loop; the top is wiring only.
//  - Shared package/include debounce_pkg: default constants.
//    DEB_STABLE_5MS = 500000, DEB_HOLD_1S = 100000000, CLK_HZ = 100000000.
// TESTING (bench uses N_CH=2, STABLE_CNT=4, HOLD_CNT=10, ACTIVE_LOW=1)
//  1. Reset with pb_in=2'b11, release rst_n, hold 20 cycles -> all outputs stay 0.
//  2. pb_in[0] 1->0 and held -> pb_press[0] is a single pulse 6 cycles later; pb_level[0]=1 from that cycle.
//  3. ch0 bounce 0,1,0,1 toggling every 2 cycles, then steady 0
//     -> no pulse during bounce; one pb_press 6 cycles after the last edge.
//  4. Hold ch0 pressed for 20 cycles after pb_press -> pb_long[0] once, 10 cycles after pb_press;
//     then release -> pb_release 6 cycles after the edge.
//  5. Press both channels on the same cycle
//     -> pb_press=2'b11 in the same cycle; ch1 released after 3 cycles -> no pb_long[1].
//  6. rst_n pulsed low while ch0 stab_cnt=2 -> outputs 0 immediately; no pulse until a fresh 2+4 cycles elapse.

Source files
------------

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//
// Purpose:
//   Shared constants and types for the push-button conditioning blocks in the
//   clk_100 domain. Holds the timing presets that board-level wrappers use to
//   parameterise debounce_multi, the default parameter values of the block
//   itself, the per-channel filter state type and a helper that sizes the
//   filter and hold counters.
//
// Ports:
//   None (package).
// -----------------------------------------------------------------------------
package debounce_pkg;

  // System clock frequency of the clk_100 domain.
  localparam int CLK_HZ = 100_000_000;

  // Timing presets expressed in clk_100 cycles.
  localparam int DEB_STABLE_5MS = 500_000;
  localparam int DEB_HOLD_1S    = 100_000_000;

  // Default parameter values of debounce_multi / debounce_ch.
  localparam int DEB_N_CH_DEF       = 4;
  localparam int DEB_STABLE_DEF     = 50_000;
  localparam int DEB_HOLD_DEF       = 10_000_000;
  localparam int DEB_ACTIVE_LOW_DEF = 1;

  // Debounced state of one button. The encoding doubles as the debounced
  // level: BTN_PRESSED drives pb_level high.
  typedef enum logic {
    BTN_RELEASED = 1'b0,
    BTN_PRESSED  = 1'b1
  } btn_state_e;

  // Number of bits needed to hold every value from 0 up to and including
  // max_val. Never returns less than 1 so a degenerate parameter still
  // yields a legal vector.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : debounce_pkg

// File: rtl/debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
//
// Purpose:
//   Conditions a single push button in the clk_100 domain:
//     - two-flop synchroniser, which also folds the button polarity so that
//       1 always means "pressed" downstream,
//     - symmetric counter-based stability filter that debounces both the
//       press and the release edge,
//     - long-press hold counter that fires once per press,
//     - registered one-cycle press / release / long-press pulses.
//
// Parameters:
//   STABLE_CNT  consecutive cycles the synchronised input must differ from
//               the debounced level before the level flips (>= 1)
//   HOLD_CNT    cycles the debounced level must stay pressed before the
//               long-press pulse fires (>= 1)
//   ACTIVE_LOW  1: pressed = pb_in low; 0: pressed = pb_in high
//
// Ports:
//   clk_100     in   1  system clock
//   rst_n       in   1  asynchronous active-low reset
//   pb_in       in   1  raw asynchronous button input
//   pb_level    out  1  debounced level, 1 = pressed
//   pb_press    out  1  one-cycle pulse on debounced 0->1
//   pb_release  out  1  one-cycle pulse on debounced 1->0
//   pb_long     out  1  one-cycle pulse after HOLD_CNT cycles pressed
// -----------------------------------------------------------------------------
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = DEB_STABLE_DEF,
  parameter int HOLD_CNT   = DEB_HOLD_DEF,
  parameter int ACTIVE_LOW = DEB_ACTIVE_LOW_DEF
) (
  input  logic clk_100,
  input  logic rst_n,
  input  logic pb_in,
  output logic pb_level,
  output logic pb_press,
  output logic pb_release,
  output logic pb_long
);

  localparam int STAB_W = cnt_width(STABLE_CNT);
  localparam int HOLD_W = cnt_width(HOLD_CNT);

  // Count value at which the next differing sample completes the window.
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CNT - 1);

  // Hold counter saturation point and the value just before it.
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CNT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CNT - 1);

  // XOR mask that turns the raw pin into "1 = pressed".
  localparam logic POL_MASK = (ACTIVE_LOW != 0);

  logic              s1;
  logic              s;
  btn_state_e        state;
  logic [STAB_W-1:0] stab_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  // Synchroniser. The polarity fold is applied on entry so both flops reset
  // to the released value and nothing downstream ever looks at raw pb_in.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= pb_in ^ POL_MASK;
      s  <= s1;
    end
  end

  // Stability filter. The level only moves after STABLE_CNT consecutive
  // samples disagree with it; any sample that agrees again throws away the
  // partial count, so bounce shorter than the window never gets through.
  // Press and release pulses are registered on the same edge that flips the
  // state, which keeps them aligned with pb_level and mutually exclusive.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BTN_RELEASED;
      stab_cnt   <= '0;
      pb_press   <= 1'b0;
      pb_release <= 1'b0;
    end else begin
      pb_press   <= 1'b0;
      pb_release <= 1'b0;
      case (state)
        BTN_RELEASED: begin
          if (!s) begin
            stab_cnt <= '0;
          end else if (stab_cnt == STAB_LAST) begin
            state    <= BTN_PRESSED;
            stab_cnt <= '0;
            pb_press <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end
        BTN_PRESSED: begin
          if (s) begin
            stab_cnt <= '0;
          end else if (stab_cnt == STAB_LAST) begin
            state      <= BTN_RELEASED;
            stab_cnt   <= '0;
            pb_release <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end
        default: begin
          state    <= BTN_RELEASED;
          stab_cnt <= '0;
        end
      endcase
    end
  end

  // Long-press timer. It works off the registered level, so it starts one
  // edge after pb_press and pb_long can never coincide with pb_press.
  // Saturating at HOLD_CNT gives exactly one pb_long per press with no
  // auto-repeat; dropping the level clears it for the next press.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      pb_long  <= 1'b0;
    end else begin
      pb_long <= 1'b0;
      if (state == BTN_RELEASED) begin
        hold_cnt <= '0;
      end else if (hold_cnt < HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          pb_long <= 1'b1;
        end
      end
    end
  end

  assign pb_level = (state == BTN_PRESSED);

endmodule : debounce_ch

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//
// Purpose:
//   N-channel push-button conditioner sitting between the board buttons and
//   the control FSMs in the clk_100 domain. Each channel is an independent
//   debounce_ch instance; this level only replicates and wires them, so
//   simultaneous events on several channels each produce their own pulses.
//
// Parameters:
//   N_CH        number of independent button channels
//   STABLE_CNT  consecutive cycles before the debounced level flips (>= 1)
//   HOLD_CNT    cycles pressed before the long-press pulse fires (>= 1)
//   ACTIVE_LOW  1: pressed = pb_in low; 0: pressed = pb_in high
//
// Ports:
//   clk_100     in   1     system clock, 100 MHz
//   rst_n       in   1     asynchronous active-low reset
//   pb_in       in   N_CH  raw asynchronous button inputs
//   pb_level    out  N_CH  debounced level, 1 = pressed
//   pb_press    out  N_CH  one-cycle pulse on debounced 0->1
//   pb_release  out  N_CH  one-cycle pulse on debounced 1->0
//   pb_long     out  N_CH  one-cycle pulse when pressed for HOLD_CNT cycles
// -----------------------------------------------------------------------------
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH       = DEB_N_CH_DEF,
  parameter int STABLE_CNT = DEB_STABLE_DEF,
  parameter int HOLD_CNT   = DEB_HOLD_DEF,
  parameter int ACTIVE_LOW = DEB_ACTIVE_LOW_DEF
) (
  input  logic            clk_100,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] pb_level,
  output logic [N_CH-1:0] pb_press,
  output logic [N_CH-1:0] pb_release,
  output logic [N_CH-1:0] pb_long
);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    debounce_ch #(
      .STABLE_CNT (STABLE_CNT),
      .HOLD_CNT   (HOLD_CNT),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk_100    (clk_100),
      .rst_n      (rst_n),
      .pb_in      (pb_in[ch]),
      .pb_level   (pb_level[ch]),
      .pb_press   (pb_press[ch]),
      .pb_release (pb_release[ch]),
      .pb_long    (pb_long[ch])
    );
  end

endmodule : debounce_multi

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
//
// Purpose:
//   Self-checking bench for debounce_multi with two active-low channels, a
//   four-cycle stability window and a ten-cycle long-press threshold. A
//   sample-history model predicts every output on every cycle; directed
//   scenarios add hand-computed literal expectations at the key cycles.
//
// Ports:
//   None (top-level bench).
// -----------------------------------------------------------------------------
module tb_debounce_multi;

  localparam int N_CH       = 2;
  localparam int STABLE_CNT = 4;
  localparam int HOLD_CNT   = 10;
  localparam int ACTIVE_LOW = 1;

  logic            clk_100 = 1'b0;
  logic            rst_n   = 1'b0;
  logic [N_CH-1:0] pb_in   = 2'b11;
  logic [N_CH-1:0] pb_level;
  logic [N_CH-1:0] pb_press;
  logic [N_CH-1:0] pb_release;
  logic [N_CH-1:0] pb_long;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: history of "pressed" samples (oldest first) and, per
  // channel, the predicted level, pulses and how long the level has been 1.
  logic [N_CH-1:0] hist [$];
  logic [N_CH-1:0] exp_level;
  logic [N_CH-1:0] exp_press;
  logic [N_CH-1:0] exp_release;
  logic [N_CH-1:0] exp_long;
  int              age [N_CH];

  debounce_multi #(
    .N_CH       (N_CH),
    .STABLE_CNT (STABLE_CNT),
    .HOLD_CNT   (HOLD_CNT),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .clk_100    (clk_100),
    .rst_n      (rst_n),
    .pb_in      (pb_in),
    .pb_level   (pb_level),
    .pb_press   (pb_press),
    .pb_release (pb_release),
    .pb_long    (pb_long)
  );

  always #5 clk_100 = ~clk_100;

  task automatic checkOutput(input string name, input logic [N_CH-1:0] act,
                             input logic [N_CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Everything pressed before reset released counts as "released" history.
  task automatic model_reset();
    hist.delete();
    repeat (STABLE_CNT + 1) hist.push_back('0);
    exp_level   = '0;
    exp_press   = '0;
    exp_release = '0;
    exp_long    = '0;
    for (int ch = 0; ch < N_CH; ch++) age[ch] = 0;
  endtask

  // A sample taken at edge k reaches the filter two edges later; the level
  // flips once the last STABLE_CNT filter samples all disagree with it.
  // The long pulse fires when the level has been 1 for exactly HOLD_CNT edges.
  task automatic model_step();
    logic [N_CH-1:0] pressed;
    logic            all_diff;
    logic            old_lvl;
    pressed = (ACTIVE_LOW != 0) ? ~pb_in : pb_in;
    hist.push_back(pressed);
    for (int ch = 0; ch < N_CH; ch++) begin
      old_lvl  = exp_level[ch];
      all_diff = 1'b1;
      for (int i = 0; i < STABLE_CNT; i++) begin
        if (hist[i][ch] == old_lvl) all_diff = 1'b0;
      end
      exp_press[ch]   = all_diff && !old_lvl;
      exp_release[ch] = all_diff && old_lvl;
      if (all_diff) exp_level[ch] = !old_lvl;
      age[ch]      = old_lvl ? age[ch] + 1 : 0;
      exp_long[ch] = (age[ch] == HOLD_CNT);
    end
    void'(hist.pop_front());
  endtask

  always @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Continuous comparison against the model on the inactive clock edge.
  always @(negedge clk_100) begin
    if (chk_en) begin
      checkOutput("model_level", pb_level, exp_level);
      checkOutput("model_press", pb_press, exp_press);
      checkOutput("model_release", pb_release, exp_release);
      checkOutput("model_long", pb_long, exp_long);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_100);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [N_CH-1:0] v);
    pb_in = v;
  endtask

  initial begin
    $display("[TB] start");
    step(3);
    chk_en = 1'b1;
    checkOutput("reset_level", pb_level, 2'b00);
    checkOutput("reset_pulses", pb_press | pb_release | pb_long, 2'b00);

    // 1: released buttons after reset keep everything quiet.
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checkOutput("t1_idle", pb_level | pb_press | pb_release | pb_long, 2'b00);
    end

    // 2: single press on ch0, then release.
    applyStimulus(2'b10);
    step(5);
    checkOutput("t2_press_early", pb_press, 2'b00);
    checkOutput("t2_level_early", pb_level, 2'b00);
    step(1);
    checkOutput("t2_press", pb_press, 2'b01);
    checkOutput("t2_level", pb_level, 2'b01);
    step(1);
    checkOutput("t2_press_after", pb_press, 2'b00);
    checkOutput("t2_level_after", pb_level, 2'b01);
    applyStimulus(2'b11);
    step(5);
    checkOutput("t2_release_early", pb_release, 2'b00);
    step(1);
    checkOutput("t2_release", pb_release, 2'b01);
    checkOutput("t2_level_rel", pb_level, 2'b00);
    step(3);

    // 3: bounce on ch0 in two-cycle runs, then steady press.
    for (int b = 0; b < 4; b++) begin
      applyStimulus((b % 2 == 0) ? 2'b10 : 2'b11);
      for (int i = 0; i < 2; i++) begin
        step(1);
        checkOutput("t3_bounce", pb_press | pb_level, 2'b00);
      end
    end
    applyStimulus(2'b10);
    step(5);
    checkOutput("t3_press_early", pb_press, 2'b00);
    step(1);
    checkOutput("t3_press", pb_press, 2'b01);

    // 4: hold ch0 for 20 cycles: one long pulse 10 cycles after press.
    for (int i = 1; i < HOLD_CNT; i++) begin
      step(1);
      checkOutput("t4_long_early", pb_long, 2'b00);
    end
    step(1);
    checkOutput("t4_long", pb_long, 2'b01);
    step(1);
    checkOutput("t4_long_after", pb_long, 2'b00);
    step(9);
    applyStimulus(2'b11);
    step(5);
    checkOutput("t4_release_early", pb_release, 2'b00);
    step(1);
    checkOutput("t4_release", pb_release, 2'b01);
    checkOutput("t4_level_rel", pb_level, 2'b00);
    step(3);

    // 5: both channels pressed together, ch1 released after 3 cycles.
    applyStimulus(2'b00);
    step(5);
    checkOutput("t5_press_early", pb_press, 2'b00);
    step(1);
    checkOutput("t5_press", pb_press, 2'b11);
    checkOutput("t5_level", pb_level, 2'b11);
    step(3);
    applyStimulus(2'b10);
    step(5);
    checkOutput("t5_rel_early", pb_release, 2'b00);
    step(1);
    checkOutput("t5_release", pb_release, 2'b10);
    checkOutput("t5_long_early", pb_long, 2'b00);
    step(1);
    checkOutput("t5_long", pb_long, 2'b01);
    checkOutput("t5_level_after", pb_level, 2'b01);

    // 6: reset in the middle of a ch0 release count (stab_cnt = 2).
    applyStimulus(2'b11);
    step(4);
    checkOutput("t6_level_pre", pb_level, 2'b01);
    rst_n = 1'b0;
    applyStimulus(2'b00);
    #1;
    checkOutput("t6_level_rst", pb_level, 2'b00);
    checkOutput("t6_pulses_rst", pb_press | pb_release | pb_long, 2'b00);
    step(2);
    rst_n = 1'b1;
    step(5);
    checkOutput("t6_press_early", pb_press, 2'b00);
    checkOutput("t6_level_early", pb_level, 2'b00);
    step(1);
    checkOutput("t6_press", pb_press, 2'b11);
    step(1);
    checkOutput("t6_press_after", pb_press, 2'b00);
    checkOutput("t6_level_after", pb_level, 2'b11);
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_debounce_multi
